regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised general-purpose register file for the pipelined CPU: two asynchronous read ports, one synchronous write port, and a register 0 that always reads as zero.
- Optional write-to-read bypass.
- Reset-time initial values that can be configured.
- Per-register pending scoreboard, set at issue and cleared at writeback, which the hazard unit uses to generate stalls.
- Sits between the decode stage (reads, issue) and the writeback stage (write).

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth NREG = 2**AW, index 0 hardwired to zero
INIT_MODE, 1, 0: all registers reset to 0; 1: reg[i] = i for 1 <= i <= INIT_CNT, all others 0
INIT_CNT, 8, number of registers given an index initial value (clamped to NREG-1)
BYPASS, 1, 1: same-cycle writeback data is forwarded to the read ports; 0: no forwarding

Ports:
clk  in  1  clock; all state updates on posedge
clr  in  1  asynchronous active-high reset
rna  in  AW  read address, port A
rnb  in  AW  read address, port B
qa  out  DW  read data, port A (combinational)
qb  out  DW  read data, port B (combinational)
we  in  1  writeback write enable
wn  in  AW  writeback destination register
d  in  DW  writeback data
iss_v  in  1  issue valid: an instruction with destination iss_rd has left decode
iss_rd  in  AW  destination register of the issuing instruction
pend_a  out  1  register rna has an outstanding producer
pend_b  out  1  register rnb has an outstanding producer
pend_cnt  out  AW  number of registers whose pending bit is set (registered)
wb_err  out  1  sticky flag: a writeback targeted a register that was not pending

Behaviour:
- Reset (clr=1, asynchronous):
  - registers take their INIT_MODE values;
  - all pending bits are cleared;
  - pend_cnt = 0 and wb_err = 0.
  - clr dominates every other input and holds the state for as long as it is high.
  - If clr asserts mid-operation, all pending state is discarded and no write lands.
- Write: on posedge, if we=1 and wn != 0, reg[wn] <= d. A write with wn = 0 is dropped.
- Read (combinational):
  - qx = 0 when rnx = 0.
  - Otherwise, when BYPASS=1 and we=1 and wn = rnx, qx = d.
  - Otherwise qx = reg[rnx].
  - With BYPASS=0, a read in the same cycle as a write returns the old value; the new value is visible from the next cycle.
- Scoreboard bit pend[i] for i >= 1; pend[0] is constant 0. On each posedge:
  - set: iss_v=1 and iss_rd != 0 sets pend[iss_rd];
  - clear: we=1 and wn != 0 clears pend[wn];
  - same register, same cycle: when iss_rd = wn, set wins and pend stays 1, because the issuing instruction is the newer producer;
  - different registers: set and clear both take effect.
- pend_a:
  - pend_a = pend[rna] & ~(BYPASS & we & (wn == rna)).
  - The bypass masks the hazard only when forwarding actually delivers the data.
  - pend_b is defined the same way for rnb.
- pend_cnt:
  - registered; next value = popcount of the next pending vector;
  - maximum value NREG-1, which fits in AW bits;
  - updated in the same edge as the pending bits.
- wb_err:
  - set on posedge when we=1, wn != 0, and pend[wn] was 0 before the edge;
  - cleared only by clr.
- No other latency: writes take 1 cycle; reads and the pend_a/pend_b outputs take 0 cycles.

Test Plan:
1. Reset with defaults → reading rna=1..8 gives 1..8, rna=9..31 gives 0, rna=0 gives 0; pend_cnt=0, wb_err=0.
2. we=1, wn=5, d=32'hDEADBEEF, rna=5 in the same cycle with BYPASS=1 → qa=DEADBEEF in that cycle. Repeat with BYPASS=0 → qa=5 in that cycle and DEADBEEF in the next.
3. iss_v=1, iss_rd=7 → next cycle pend_a=1 for rna=7 and pend_cnt=1. Then we=1, wn=7, d=42 → pend_a=0 during that cycle (BYPASS=1) with qa=42; next cycle pend_cnt=0 and wb_err=0.
4. Register 7 pending; same cycle iss_v=1, iss_rd=7 and we=1, wn=7 → pend[7] stays 1, pend_cnt stays 1, reg[7] gets d.
5. we=1, wn=0, d=FFFFFFFF and iss_v=1, iss_rd=0 → rna=0 reads 0, pend_cnt is unchanged, wb_err=0. Then we=1, wn=3 with register 3 not pending → wb_err=1 and it stays 1.
6. Issue registers 1..31 on consecutive cycles → pend_cnt reaches 31. Assert clr asynchronously between clock edges → pend_cnt=0 and all pend bits 0 immediately, and reg[2]=2.

Source files
------------

// File: rtl/regfile_sb.sv
// General-purpose register file: two combinational read ports, one synchronous write port,
// optional writeback bypass and a per-register pending scoreboard for the hazard unit.
module regfile_sb #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned INIT_MODE = 1,
    parameter int unsigned INIT_CNT  = 8,
    parameter int unsigned BYPASS    = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          we,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic          iss_v,
    input  logic [AW-1:0] iss_rd,
    output logic          pend_a,
    output logic          pend_b,
    output logic [AW-1:0] pend_cnt,
    output logic          wb_err
);

    localparam int unsigned NREG = 2 ** AW;
    localparam int unsigned ICNT = (INIT_CNT > NREG - 1) ? NREG - 1 : INIT_CNT;
    localparam logic        BYP  = (BYPASS != 0);

    function automatic logic [DW-1:0] init_val(input int unsigned idx);
        if (INIT_MODE == 1 && idx >= 1 && idx <= ICNT) begin
            return DW'(idx);
        end
        return '0;
    endfunction

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;

    logic wr_en, iss_en, fwd_a, fwd_b;

    assign wr_en  = we && (wn != '0);
    assign iss_en = iss_v && (iss_rd != '0);
    assign fwd_a  = BYP && we && (wn == rna);
    assign fwd_b  = BYP && we && (wn == rnb);

    // Register storage; entry 0 is never written so it holds its zero reset value.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= init_val(i);
            end
        end else if (wr_en) begin
            regs[wn] <= d;
        end
    end

    assign qa = (rna == '0) ? '0 : fwd_a ? d : regs[rna];
    assign qb = (rnb == '0) ? '0 : fwd_b ? d : regs[rnb];

    // Set is applied after clear so a same-register issue (the newer producer) wins.
    always_comb begin
        int unsigned cnt;
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[wn] = 1'b0;
        end
        if (iss_en) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;

        cnt = 0;
        for (int i = 1; i < NREG; i++) begin
            cnt = cnt + {31'd0, pend_d[i]};
        end
        cnt_d = AW'(cnt);

        err_d = err_q | (wr_en & ~pend_q[wn]);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // A forwarded writeback delivers the data, so it also resolves the hazard.
    assign pend_a   = pend_q[rna] & ~fwd_a;
    assign pend_b   = pend_q[rnb] & ~fwd_b;
    assign pend_cnt = cnt_q;
    assign wb_err   = err_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb, with a bypassing and a non-bypassing instance.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  rna, rnb, wn, iss_rd;
    logic [31:0] d;
    logic        we, iss_v;

    logic [31:0] qa1, qb1, qa0, qb0;
    logic        pa1, pb1, pa0, pb0, err1, err0;
    logic [4:0]  cnt1, cnt0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.BYPASS(1)) u_byp (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
        .we(we), .wn(wn), .d(d), .iss_v(iss_v), .iss_rd(iss_rd),
        .pend_a(pa1), .pend_b(pb1), .pend_cnt(cnt1), .wb_err(err1)
    );

    regfile_sb #(.BYPASS(0)) u_nob (
        .clk(clk), .clr(clr), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .we(we), .wn(wn), .d(d), .iss_v(iss_v), .iss_rd(iss_rd),
        .pend_a(pa0), .pend_b(pb0), .pend_cnt(cnt0), .wb_err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b1; rna = '0; rnb = '0; we = 1'b0; wn = '0; d = '0;
        iss_v = 1'b0; iss_rd = '0;
        #12 clr = 1'b0;
        #1;

        // Reset values: reg[i] = i for 1..8, all others 0
        for (int i = 0; i < 32; i++) begin
            rna = 5'(i);
            #1;
            chk($sformatf("init_qa[%0d]", i), qa1, (i >= 1 && i <= 8) ? 32'(i) : 32'd0);
        end
        chk("init_cnt", {27'd0, cnt1}, 32'd0);
        chk("init_err", {31'd0, err1}, 32'd0);

        // Same-cycle write: bypass forwards, no-bypass shows old value then new
        tick();
        rna = 5'd5; we = 1'b1; wn = 5'd5; d = 32'hDEADBEEF;
        #1;
        chk("byp_qa_same", qa1, 32'hDEADBEEF);
        chk("nob_qa_same", qa0, 32'd5);
        tick();
        we = 1'b0;
        #1;
        chk("nob_qa_next", qa0, 32'hDEADBEEF);
        chk("wb_err_unpend", {31'd0, err1}, 32'd1);

        // Asynchronous reset between edges restores init values and clears wb_err
        @(negedge clk);
        clr = 1'b1;
        #1;
        clr = 1'b0;
        #1;
        chk("rst_qa5", qa1, 32'd5);
        chk("rst_err", {31'd0, err1}, 32'd0);

        // Issue then writeback of reg 7
        tick();
        iss_v = 1'b1; iss_rd = 5'd7;
        tick();
        iss_v = 1'b0; rna = 5'd7;
        #1;
        chk("iss_pend_a", {31'd0, pa1}, 32'd1);
        chk("iss_cnt", {27'd0, cnt1}, 32'd1);
        we = 1'b1; wn = 5'd7; d = 32'd42;
        #1;
        chk("wb_pend_a_byp", {31'd0, pa1}, 32'd0);
        chk("wb_qa_byp", qa1, 32'd42);
        chk("wb_pend_a_nob", {31'd0, pa0}, 32'd1);
        chk("wb_qa_nob", qa0, 32'd7);
        tick();
        we = 1'b0;
        #1;
        chk("wb_cnt", {27'd0, cnt1}, 32'd0);
        chk("wb_err", {31'd0, err1}, 32'd0);
        chk("wb_qa_after", qa1, 32'd42);

        // Same-register issue and writeback: set wins, data still lands
        iss_v = 1'b1; iss_rd = 5'd7;
        tick();
        we = 1'b1; wn = 5'd7; d = 32'd99;
        tick();
        iss_v = 1'b0; we = 1'b0;
        #1;
        chk("same_pend_a", {31'd0, pa1}, 32'd1);
        chk("same_cnt", {27'd0, cnt1}, 32'd1);
        chk("same_qa", qa1, 32'd99);
        chk("same_err", {31'd0, err1}, 32'd0);

        // Different registers: issue 9 while 7 writes back
        iss_v = 1'b1; iss_rd = 5'd9; we = 1'b1; wn = 5'd7; d = 32'd100;
        tick();
        iss_v = 1'b0; we = 1'b0; rna = 5'd9; rnb = 5'd7;
        #1;
        chk("diff_cnt", {27'd0, cnt1}, 32'd1);
        chk("diff_pend_a", {31'd0, pa1}, 32'd1);
        chk("diff_pend_b", {31'd0, pb1}, 32'd0);
        chk("diff_qb", qb1, 32'd100);

        // Register 0: writes and issues are dropped
        rna = 5'd0; we = 1'b1; wn = 5'd0; d = 32'hFFFFFFFF; iss_v = 1'b1; iss_rd = 5'd0;
        #1;
        chk("r0_qa_same", qa1, 32'd0);
        chk("r0_pend_a", {31'd0, pa1}, 32'd0);
        tick();
        we = 1'b0; iss_v = 1'b0;
        #1;
        chk("r0_qa", qa1, 32'd0);
        chk("r0_cnt", {27'd0, cnt1}, 32'd1);
        chk("r0_err", {31'd0, err1}, 32'd0);

        // Writeback to a non-pending register sets the sticky error
        we = 1'b1; wn = 5'd3; d = 32'd33;
        tick();
        we = 1'b0; rna = 5'd3;
        #1;
        chk("err_set", {31'd0, err1}, 32'd1);
        chk("err_qa3", qa1, 32'd33);
        tick();
        tick();
        chk("err_sticky", {31'd0, err1}, 32'd1);
        chk("err_cnt", {27'd0, cnt1}, 32'd1);

        // Fill the scoreboard (reg 9 already pending)
        for (int i = 1; i < 32; i++) begin
            iss_v = 1'b1; iss_rd = 5'(i);
            tick();
            if (i == 16) begin
                chk("fill_cnt16", {27'd0, cnt1}, 32'd16);
            end
        end
        iss_v = 1'b0;
        #1;
        chk("fill_cnt", {27'd0, cnt1}, 32'd31);
        chk("fill_cnt_nob", {27'd0, cnt0}, 32'd31);

        // Asynchronous clear mid-operation
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_cnt", {27'd0, cnt1}, 32'd0);
        chk("clr_err", {31'd0, err1}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            rna = 5'(i);
            #1;
            chk($sformatf("clr_pend[%0d]", i), {31'd0, pa1}, 32'd0);
        end
        rnb = 5'd2;
        #1;
        chk("clr_qb2", qb1, 32'd2);

        // Held clear blocks writes and issues at the edge
        we = 1'b1; wn = 5'd2; d = 32'd123; iss_v = 1'b1; iss_rd = 5'd2;
        tick();
        we = 1'b0; iss_v = 1'b0;
        #1;
        chk("clr_hold_qb2", qb1, 32'd2);
        chk("clr_hold_cnt", {27'd0, cnt1}, 32'd0);
        rna = 5'd3;
        #1;
        chk("clr_qa3", qa1, 32'd3);
        clr = 1'b0;
        #1;
        chk("clr_rel_pend_b", {31'd0, pb1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
